// File: rtl/waxi_loader.sv
// AXI4 single-beat write master fed by a small request FIFO.
// Each request runs a strictly ordered AW -> W -> B sequence; completions and bad responses are tracked.
module waxi_loader #(
  parameter int ByteLength = 8,
  parameter int AddrWidth  = 32,
  parameter int DataWidth  = 32,
  parameter int IdWidth    = 8,
  parameter int FifoDepth  = 4,
  parameter int AxiId      = 0
) (
  input  logic                            axi_clk_i,
  input  logic                            rstn_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [AddrWidth-1:0]            req_addr_i,
  input  logic [DataWidth-1:0]            req_data_i,
  input  logic [DataWidth/ByteLength-1:0] req_strb_i,
  output logic [IdWidth-1:0]              m_axi_awid_o,
  output logic [AddrWidth-1:0]            m_axi_awaddr_o,
  output logic [7:0]                      m_axi_awlen_o,
  output logic [2:0]                      m_axi_awsize_o,
  output logic [1:0]                      m_axi_awburst_o,
  output logic [1:0]                      m_axi_awlock_o,
  output logic [3:0]                      m_axi_awcache_o,
  output logic [2:0]                      m_axi_awprot_o,
  output logic                            m_axi_awvalid_o,
  input  logic                            m_axi_awready_i,
  output logic [DataWidth-1:0]            m_axi_wdata_o,
  output logic [DataWidth/ByteLength-1:0] m_axi_wstrb_o,
  output logic                            m_axi_wlast_o,
  output logic                            m_axi_wvalid_o,
  input  logic                            m_axi_wready_i,
  input  logic [IdWidth-1:0]              m_axi_bid_i,
  input  logic [1:0]                      m_axi_bresp_i,
  input  logic                            m_axi_bvalid_i,
  output logic                            m_axi_bready_o,
  input  logic                            clear_i,
  output logic                            busy_o,
  output logic [31:0]                     done_count_o,
  output logic                            error_o
);

  localparam int StrbWidth = DataWidth / ByteLength;
  localparam int IdxWidth  = $clog2(FifoDepth);
  localparam int PtrWidth  = IdxWidth + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t state, state_next;

  logic [AddrWidth-1:0] fifo_addr [FifoDepth];
  logic [DataWidth-1:0] fifo_data [FifoDepth];
  logic [StrbWidth-1:0] fifo_strb [FifoDepth];
  logic [PtrWidth-1:0]  wr_ptr, rd_ptr;
  logic                 full, empty, push, pop, b_done;

  logic [AddrWidth-1:0] hold_addr;
  logic [DataWidth-1:0] hold_data;
  logic [StrbWidth-1:0] hold_strb;

  logic unused_bid;
  assign unused_bid = ^m_axi_bid_i;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PtrWidth-1] != rd_ptr[PtrWidth-1]) &&
                 (wr_ptr[IdxWidth-1:0] == rd_ptr[IdxWidth-1:0]);
  assign req_ready_o = !full;
  assign push   = req_valid_i && !full;
  assign pop    = (state == IDLE) && !empty;
  assign b_done = (state == RESP) && m_axi_bvalid_i;

  always_ff @(posedge axi_clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr[IdxWidth-1:0]] <= req_addr_i;
      fifo_data[wr_ptr[IdxWidth-1:0]] <= req_data_i;
      fifo_strb[wr_ptr[IdxWidth-1:0]] <= req_strb_i;
    end
  end

  always_ff @(posedge axi_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // The head entry moves into the holding register so AW/W payloads stay stable while the FIFO keeps filling.
  always_ff @(posedge axi_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hold_addr <= '0;
      hold_data <= '0;
      hold_strb <= '0;
    end else if (pop) begin
      hold_addr <= fifo_addr[rd_ptr[IdxWidth-1:0]];
      hold_data <= fifo_data[rd_ptr[IdxWidth-1:0]];
      hold_strb <= fifo_strb[rd_ptr[IdxWidth-1:0]];
    end
  end

  always_ff @(posedge axi_clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next      = state;
    m_axi_awvalid_o = 1'b0;
    m_axi_wvalid_o  = 1'b0;
    m_axi_bready_o  = 1'b0;
    case (state)
      IDLE: if (!empty) state_next = ADDR;
      ADDR: begin
        m_axi_awvalid_o = 1'b1;
        if (m_axi_awready_i) state_next = DATA;
      end
      DATA: begin
        m_axi_wvalid_o = 1'b1;
        if (m_axi_wready_i) state_next = RESP;
      end
      RESP: begin
        m_axi_bready_o = 1'b1;
        if (m_axi_bvalid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A clear in the same cycle as a completion takes priority.
  always_ff @(posedge axi_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      done_count_o <= '0;
      error_o      <= 1'b0;
    end else if (clear_i) begin
      done_count_o <= '0;
      error_o      <= 1'b0;
    end else if (b_done) begin
      done_count_o <= done_count_o + 32'd1;
      if (m_axi_bresp_i != 2'b00) error_o <= 1'b1;
    end
  end

  assign busy_o          = !empty || (state != IDLE);
  assign m_axi_awid_o    = IdWidth'(AxiId);
  assign m_axi_awaddr_o  = hold_addr;
  assign m_axi_awlen_o   = 8'd0;
  assign m_axi_awsize_o  = 3'($clog2(StrbWidth));
  assign m_axi_awburst_o = 2'b01;
  assign m_axi_awlock_o  = 2'b00;
  assign m_axi_awcache_o = 4'd0;
  assign m_axi_awprot_o  = 3'd0;
  assign m_axi_wdata_o   = hold_data;
  assign m_axi_wstrb_o   = hold_strb;
  assign m_axi_wlast_o   = m_axi_wvalid_o;

endmodule
